// File: rtl/mem_wr_pipe.sv
`default_nettype none
// ============================================================================
// mem_wr_pipe : parametrised MEM->WR pipeline register with writeback mux,
//               EX-stage forwarding lookup and saturating bubble counter.
// Revision    : 1.0
// ============================================================================
module mem_wr_pipe #(
  parameter int DW    = 32,
  parameter int AW    = 5,
  parameter int DEPTH = 1,
  parameter int CNTW  = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic            valid_mem,
  input  logic [DW-1:0]   dmout_mem,
  input  logic [DW-1:0]   ALUout_mem,
  input  logic [AW-1:0]   rw_mem,
  input  logic            MemtoReg_mem,
  input  logic            RegWr_mem,
  input  logic [AW-1:0]   rs_ex,
  input  logic [AW-1:0]   rt_ex,
  output logic            valid_wr,
  output logic [DW-1:0]   dmout_wr,
  output logic [DW-1:0]   ALUout_wr,
  output logic [AW-1:0]   rw_wr,
  output logic            MemtoReg_wr,
  output logic            RegWr_wr,
  output logic [DW-1:0]   wdata_wr,
  output logic            we_wr,
  output logic            fwd_hit_rs,
  output logic [DW-1:0]   fwd_data_rs,
  output logic            fwd_hit_rt,
  output logic [DW-1:0]   fwd_data_rt,
  output logic [CNTW-1:0] bubble_cnt
);

  localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};
  localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};

  logic [DEPTH-1:0]         valid_q,    valid_d;
  logic [DEPTH-1:0]         memtoreg_q, memtoreg_d;
  logic [DEPTH-1:0]         regwr_q,    regwr_d;
  logic [DEPTH-1:0][DW-1:0] dmout_q,    dmout_d;
  logic [DEPTH-1:0][DW-1:0] aluout_q,   aluout_d;
  logic [DEPTH-1:0][AW-1:0] rw_q,       rw_d;
  logic [CNTW-1:0]          bubble_cnt_q, bubble_cnt_d;

  always_comb begin
    valid_d      = valid_q;
    memtoreg_d   = memtoreg_q;
    regwr_d      = regwr_q;
    dmout_d      = dmout_q;
    aluout_d     = aluout_q;
    rw_d         = rw_q;
    bubble_cnt_d = bubble_cnt_q;

    if (!stall) begin
      for (int i = 1; i < DEPTH; i++) begin
        valid_d[i]    = valid_q[i-1];
        memtoreg_d[i] = memtoreg_q[i-1];
        regwr_d[i]    = regwr_q[i-1];
        dmout_d[i]    = dmout_q[i-1];
        aluout_d[i]   = aluout_q[i-1];
        rw_d[i]       = rw_q[i-1];
      end
    end

    // Flush clears stage 0 whether or not the pipe is stalled.
    if (flush) begin
      valid_d[0]    = 1'b0;
      memtoreg_d[0] = 1'b0;
      regwr_d[0]    = 1'b0;
      dmout_d[0]    = '0;
      aluout_d[0]   = '0;
      rw_d[0]       = '0;
    end else if (!stall) begin
      valid_d[0]    = valid_mem;
      memtoreg_d[0] = MemtoReg_mem & valid_mem;
      regwr_d[0]    = RegWr_mem & valid_mem;
      dmout_d[0]    = dmout_mem;
      aluout_d[0]   = ALUout_mem;
      rw_d[0]       = rw_mem;
    end

    if (!stall && !valid_d[DEPTH-1] && bubble_cnt_q != CNT_MAX) begin
      bubble_cnt_d = bubble_cnt_q + CNT_ONE;
    end
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      valid_q      <= '0;
      memtoreg_q   <= '0;
      regwr_q      <= '0;
      dmout_q      <= '0;
      aluout_q     <= '0;
      rw_q         <= '0;
      bubble_cnt_q <= '0;
    end else begin
      valid_q      <= valid_d;
      memtoreg_q   <= memtoreg_d;
      regwr_q      <= regwr_d;
      dmout_q      <= dmout_d;
      aluout_q     <= aluout_d;
      rw_q         <= rw_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  // Scan oldest to youngest so the youngest matching stage wins.
  always_comb begin
    fwd_hit_rs  = 1'b0;
    fwd_data_rs = '0;
    fwd_hit_rt  = 1'b0;
    fwd_data_rt = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (valid_q[i] && regwr_q[i] && rw_q[i] != '0 && rw_q[i] == rs_ex) begin
        fwd_hit_rs  = 1'b1;
        fwd_data_rs = memtoreg_q[i] ? dmout_q[i] : aluout_q[i];
      end
      if (valid_q[i] && regwr_q[i] && rw_q[i] != '0 && rw_q[i] == rt_ex) begin
        fwd_hit_rt  = 1'b1;
        fwd_data_rt = memtoreg_q[i] ? dmout_q[i] : aluout_q[i];
      end
    end
  end

  assign valid_wr    = valid_q[DEPTH-1];
  assign dmout_wr    = dmout_q[DEPTH-1];
  assign ALUout_wr   = aluout_q[DEPTH-1];
  assign rw_wr       = rw_q[DEPTH-1];
  assign MemtoReg_wr = memtoreg_q[DEPTH-1];
  assign RegWr_wr    = regwr_q[DEPTH-1];
  assign wdata_wr    = MemtoReg_wr ? dmout_wr : ALUout_wr;
  assign we_wr       = RegWr_wr & valid_wr & (rw_wr != '0);
  assign bubble_cnt  = bubble_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_wr_pipe.sv
`default_nettype none
// ============================================================================
// tb_mem_wr_pipe : scoreboard bench for mem_wr_pipe (DEPTH=3, CNTW=4).
// Revision       : 1.0
// ============================================================================
module tb_mem_wr_pipe;
  localparam int DW = 32, AW = 5, D = 3, CNTW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic stall = 0, flush = 0, valid_mem = 0, MemtoReg_mem = 0, RegWr_mem = 0;
  logic [DW-1:0] dmout_mem = '0, ALUout_mem = '0;
  logic [AW-1:0] rw_mem = '0, rs_ex = '0, rt_ex = '0;
  logic valid_wr, MemtoReg_wr, RegWr_wr, we_wr, fwd_hit_rs, fwd_hit_rt;
  logic [DW-1:0] dmout_wr, ALUout_wr, wdata_wr, fwd_data_rs, fwd_data_rt;
  logic [AW-1:0] rw_wr;
  logic [CNTW-1:0] bubble_cnt;

  mem_wr_pipe #(.DW(DW), .AW(AW), .DEPTH(D), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .valid_mem(valid_mem),
    .dmout_mem(dmout_mem), .ALUout_mem(ALUout_mem), .rw_mem(rw_mem),
    .MemtoReg_mem(MemtoReg_mem), .RegWr_mem(RegWr_mem), .rs_ex(rs_ex), .rt_ex(rt_ex),
    .valid_wr(valid_wr), .dmout_wr(dmout_wr), .ALUout_wr(ALUout_wr), .rw_wr(rw_wr),
    .MemtoReg_wr(MemtoReg_wr), .RegWr_wr(RegWr_wr), .wdata_wr(wdata_wr), .we_wr(we_wr),
    .fwd_hit_rs(fwd_hit_rs), .fwd_data_rs(fwd_data_rs), .fwd_hit_rt(fwd_hit_rt),
    .fwd_data_rt(fwd_data_rt), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one record per stage, index 0 youngest.
  typedef struct {
    logic          v, m2r, rwr;
    logic [DW-1:0] dm, alu;
    logic [AW-1:0] rw;
  } ent_t;

  typedef struct {
    ent_t          last;
    logic [DW-1:0] wd;
    logic          we, hrs, hrt;
    logic [DW-1:0] drs, drt;
    int            cnt;
  } exp_t;

  ent_t m_st[D];
  int   m_cnt = 0;
  exp_t sb[$];

  function automatic ent_t zero_ent();
    ent_t e;
    e.v = 0; e.m2r = 0; e.rwr = 0; e.dm = '0; e.alu = '0; e.rw = '0;
    return e;
  endfunction

  function automatic logic [DW:0] lookup(input logic [AW-1:0] r);
    for (int i = 0; i < D; i++)
      if (r != 0 && m_st[i].v && m_st[i].rwr && m_st[i].rw == r)
        return {1'b1, m_st[i].m2r ? m_st[i].dm : m_st[i].alu};
    return '0;
  endfunction

  function automatic exp_t snapshot();
    exp_t e;
    logic [DW:0] f;
    e.last = m_st[D-1];
    e.wd   = e.last.m2r ? e.last.dm : e.last.alu;
    e.we   = e.last.rwr && e.last.v && e.last.rw != 0;
    f = lookup(rs_ex); e.hrs = f[DW]; e.drs = f[DW-1:0];
    f = lookup(rt_ex); e.hrt = f[DW]; e.drt = f[DW-1:0];
    e.cnt = m_cnt;
    return e;
  endfunction

  always @(negedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < D; i++) m_st[i] = zero_ent();
      m_cnt = 0;
    end else if (!stall) begin
      for (int i = D - 1; i > 0; i--) m_st[i] = m_st[i-1];
      if (flush) m_st[0] = zero_ent();
      else begin
        m_st[0].v = valid_mem;     m_st[0].dm = dmout_mem; m_st[0].alu = ALUout_mem;
        m_st[0].rw = rw_mem;       m_st[0].m2r = MemtoReg_mem && valid_mem;
        m_st[0].rwr = RegWr_mem && valid_mem;
      end
      if (!m_st[D-1].v && m_cnt < (1 << CNTW) - 1) m_cnt++;
    end else if (flush) begin
      m_st[0] = zero_ent();
    end
    if (clk == 1'b0) sb.push_back(snapshot());
  end

  // Monitor: outputs are stable on the rising edge, half a cycle after capture.
  always @(posedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("valid_wr",  valid_wr,  e.last.v);
      chk("dmout_wr",  dmout_wr,  e.last.dm);
      chk("ALUout_wr", ALUout_wr, e.last.alu);
      chk("rw_wr",     rw_wr,     e.last.rw);
      chk("ctrl_wr",   {MemtoReg_wr, RegWr_wr}, {e.last.m2r, e.last.rwr});
      chk("wdata_wr",  wdata_wr,  e.wd);
      chk("we_wr",     we_wr,     e.we);
      chk("fwd_rs",    {fwd_hit_rs, fwd_data_rs}, {e.hrs, e.drs});
      chk("fwd_rt",    {fwd_hit_rt, fwd_data_rt}, {e.hrt, e.drt});
      chk("bubble_cnt", bubble_cnt, e.cnt[CNTW-1:0]);
    end
  end

  task automatic set_in(input logic v, input logic [DW-1:0] dm, input logic [DW-1:0] alu,
                        input logic [AW-1:0] rw, input logic m2r, input logic rwr,
                        input logic st, input logic fl);
    valid_mem = v; dmout_mem = dm; ALUout_mem = alu; rw_mem = rw;
    MemtoReg_mem = m2r; RegWr_mem = rwr; stall = st; flush = fl;
  endtask

  task automatic step();
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic bubble(input int n);
    set_in(0, '0, '0, '0, 0, 0, 0, 0);
    repeat (n) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    #2;
    chk("reset_valid_wr", valid_wr, 0);
    chk("reset_wdata_wr", wdata_wr, 0);
    chk("reset_fwd_rs", {fwd_hit_rs, fwd_data_rs}, 0);
    step();
    step();
    rst = 1'b0;

    // Pass-through: visible after D falling edges.
    set_in(1, 32'hDEAD, 32'h0000_1234, 5'd8, 0, 1, 0, 0);
    step();
    bubble(1);
    chk("pass_not_yet", valid_wr, 0);
    bubble(1);
    chk("pass_wdata", wdata_wr, 32'h1234);
    chk("pass_we", we_wr, 1);
    chk("pass_rw", rw_wr, 8);

    // Write to r0 is suppressed.
    set_in(1, '0, 32'h55, 5'd0, 0, 1, 0, 0);
    step();
    bubble(2);
    chk("r0_valid", valid_wr, 1);
    chk("r0_we", we_wr, 0);

    // Stall holds every stage regardless of inputs.
    set_in(1, '0, 32'h99, 5'd9, 0, 1, 0, 0);
    step();
    bubble(2);
    chk("stall_load_rw", rw_wr, 9);
    for (int i = 0; i < 3; i++) begin
      set_in(1, $urandom, $urandom, 5'($urandom_range(10, 31)), 1, 1, 1, 0);
      step();
      chk("stall_hold_rw", rw_wr, 9);
      chk("stall_hold_v", valid_wr, 1);
    end
    set_in(1, '0, '0, 5'd4, 0, 1, 1, 1);
    step();
    chk("flush_stall_last_hold", rw_wr, 9);

    // Forwarding: youngest matching stage wins, r0 never hits.
    rs_ex = 5'd5;
    rt_ex = 5'd0;
    set_in(1, 32'hBB, 32'h11, 5'd5, 1, 1, 0, 0); step();
    set_in(1, 32'h0,  32'h22, 5'd7, 0, 1, 0, 0); step();
    set_in(1, 32'h33, 32'hAA, 5'd5, 0, 1, 0, 0); step();
    chk("fwd_young_hit", fwd_hit_rs, 1);
    chk("fwd_young_data", fwd_data_rs, 32'hAA);
    chk("fwd_rt0", fwd_hit_rt, 0);
    chk("fwd_last_wdata", wdata_wr, 32'hBB);
    set_in(0, '0, '0, '0, 0, 0, 1, 1); step();
    chk("fwd_old_data", fwd_data_rs, 32'hBB);
    chk("fwd_old_hit", fwd_hit_rs, 1);
    rt_ex = 5'd7;
    #1;
    chk("fwd_rt_mid", {fwd_hit_rt, fwd_data_rt}, {1'b1, 32'h22});

    // Randomised traffic checked by the scoreboard.
    for (int n = 0; n < 400; n++) begin
      set_in(1'($urandom), $urandom, $urandom, 5'($urandom_range(0, 7)),
             1'($urandom), 1'($urandom),
             $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
      rs_ex = 5'($urandom_range(0, 7));
      rt_ex = 5'($urandom_range(0, 7));
      step();
    end

    // Asynchronous reset mid-stream.
    rs_ex = 5'd3;
    for (int i = 0; i < D; i++) begin
      set_in(1, '0, 32'(i + 1), 5'd3, 0, 1, 0, 0);
      step();
    end
    chk("pre_rst_valid", valid_wr, 1);
    chk("pre_rst_hit", fwd_hit_rs, 1);
    rst = 1'b1;
    #1;
    chk("async_rst_valid", valid_wr, 0);
    chk("async_rst_we", {we_wr, RegWr_wr, rw_wr}, 0);
    chk("async_rst_fwd", {fwd_hit_rs, fwd_data_rs}, 0);
    chk("async_rst_cnt", bubble_cnt, 0);
    step();
    rst = 1'b0;
    set_in(1, '0, 32'h77, 5'd6, 0, 1, 0, 0);
    step();
    bubble(1);
    chk("post_rst_early", valid_wr, 0);
    bubble(1);
    chk("post_rst_arrive", {valid_wr, ALUout_wr}, {1'b1, 32'h77});

    // Bubble counter: stalled cycles excluded, saturates at 2^CNTW-1.
    do_reset();
    chk("cnt_after_rst", bubble_cnt, 0);
    bubble(5);
    chk("cnt_five", bubble_cnt, 5);
    set_in(0, '0, '0, '0, 0, 0, 1, 0);
    repeat (3) step();
    chk("cnt_stall_nocount", bubble_cnt, 5);
    bubble(15);
    chk("cnt_saturate", bubble_cnt, 15);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire

// File: doc/mem_wr_pipe.md
Name: mem_wr_pipe

Overview:
- Parametrised MEM→WR pipeline register; successor to the fixed 71-bit MEM/WR latch.
- Adds async reset, a valid bit, stall/flush control and a configurable stage count (DEPTH) for multi-cycle writeback latency.
- Adds a built-in writeback mux, forwarding lookup for the EX stage, and a saturating bubble counter.
- Sits between the data-memory stage and the register file / forwarding unit.

Parameters:
- DW, 32, data width of dmout/ALUout/wdata
- AW, 5, register-address width
- DEPTH, 1, number of pipeline stages (legal 1..4); stage 0 is youngest, stage DEPTH-1 drives the *_wr outputs
- CNTW, 16, bubble-counter width

Ports:
- clk  in  1  pipeline clock; all state captured on the falling edge
- rst  in  1  asynchronous, active-high reset
- stall  in  1  hold all stages
- flush  in  1  replace the incoming MEM instruction with a bubble
- valid_mem  in  1  MEM-stage instruction valid
- dmout_mem  in  DW  data-memory read data
- ALUout_mem  in  DW  ALU result
- rw_mem  in  AW  destination register
- MemtoReg_mem  in  1  writeback source select (1 = dmout)
- RegWr_mem  in  1  register write enable
- rs_ex  in  AW  EX-stage source register 1
- rt_ex  in  AW  EX-stage source register 2
- valid_wr  out  1  last-stage valid
- dmout_wr  out  DW  last-stage dmout
- ALUout_wr  out  DW  last-stage ALUout
- rw_wr  out  AW  last-stage destination
- MemtoReg_wr  out  1  last-stage select
- RegWr_wr  out  1  last-stage write enable (raw)
- wdata_wr  out  DW  MemtoReg_wr ? dmout_wr : ALUout_wr
- we_wr  out  1  RegWr_wr & valid_wr & (rw_wr != 0)
- fwd_hit_rs  out  1  rs_ex matches a pending write
- fwd_data_rs  out  DW  forwarded value for rs
- fwd_hit_rt  out  1  rt_ex matches a pending write
- fwd_data_rt  out  DW  forwarded value for rt
- bubble_cnt  out  CNTW  saturating count of bubble cycles at the last stage

Behaviour:
- Reset (async, rst=1): every stage is cleared (valid, ctrl, data, rw = 0) and bubble_cnt = 0. All *_wr outputs, wdata_wr and we_wr read 0; fwd_hit_* = 0 and fwd_data_* = 0. Reset applied mid-operation discards all in-flight entries immediately, without waiting for a clock edge.
- Falling-edge update priority (rst excluded): flush&stall > stall > flush > normal.
  - Normal: stage0 ← MEM inputs; stage i ← stage i-1.
  - stall=1, flush=0: all stages hold, including valid.
  - flush=1, stall=0: stages shift as normal; stage0 loads a bubble (all fields 0).
  - flush=1, stall=1: stages 1..DEPTH-1 hold; stage0 is cleared to a bubble in place.
- Bubble input: valid_mem=0 with no flush still loads the data fields. RegWr and MemtoReg are stored as 0 whenever the stored valid is 0.
- Latency: DEPTH falling edges from MEM inputs to *_wr outputs. With DEPTH=1 the timing matches the legacy MEM/WR register.
- wdata_wr, we_wr, fwd_*: purely combinational from stored state; no clock delay.
- Forwarding lookup:
  - Candidate stage = valid & RegWr & rw != 0 & rw == rs_ex (or rt_ex).
  - Youngest candidate (lowest stage index) wins.
  - fwd_data = candidate MemtoReg ? dmout : ALUout. With no hit, fwd_data = 0.
  - rs_ex = 0 never hits.
- bubble_cnt: on each falling edge with stall=0, it increments if the value being loaded into the last stage has valid=0. It saturates at 2^CNTW-1 and is cleared only by rst.
- No X propagation: every register has a defined reset value.

Test Plan:
- Reset: assert rst mid-stream with DEPTH=2 and two valid entries → outputs go 0 before the next clk edge; after release, the first valid entry appears after 2 falling edges.
- Pass-through, DEPTH=1: drive valid, ALUout=0x0000_1234, rw=8, RegWr=1, MemtoReg=0 → after 1 falling edge, wdata_wr=0x1234, we_wr=1, rw_wr=8.
- Stall/flush, DEPTH=1:
  - Load an entry with rw=9, then stall for 3 cycles while changing the inputs → outputs stay rw=9.
  - Assert flush&stall → valid_wr=0, we_wr=0.
- Forwarding, DEPTH=3:
  - Stage0 holds rw=5, ALUout=0xAA. Stage2 holds rw=5, MemtoReg=1, dmout=0xBB. rs_ex=5 → fwd_hit_rs=1, fwd_data_rs=0xAA.
  - Invalidate stage0 → fwd_data_rs=0xBB.
  - rt_ex=0 → fwd_hit_rt=0.
- Writeback with rw=0: RegWr=1, rw=0, valid=1 → we_wr=0.
- Counter: CNTW=4, feed 20 bubble cycles (no stall) → bubble_cnt saturates at 15; stalled cycles do not count.
